spi_shifter: RTL and testbench
==============================

# spi_shifter

SPI master shift engine that sits directly downstream of the TX FIFO in the SPI peripheral. It pops one word from the FIFO when data is available, serialises it MSB-first on MOSI in SPI mode 0 (CPOL=0, CPHA=0), and captures MISO in parallel. Each received word is presented to the RX path with a one-cycle valid strobe. All logic runs on PCLK.

## Interface
- DATA_WIDTH, 8: bits per SPI frame; must be ≥2.
- CLK_DIV, 2: PCLK cycles per SCLK half-period; must be ≥1.

- PCLK  in  1  peripheral clock; all state changes on its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  permits new frames to start; sampled only in IDLE.
- TX_EMPTY  in  1  TX FIFO empty flag.
- TX_DATA  in  DATA_WIDTH  FIFO read data; valid the cycle after TX_POP.
- TX_POP  out  1  one-cycle FIFO read strobe.
- RX_DATA  out  DATA_WIDTH  last received word; held until the next frame completes.
- RX_VALID  out  1  one-cycle pulse when RX_DATA updates.
- BUSY  out  1  high in every state except IDLE.
- SCLK  out  1  SPI clock; idles low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- CS_N  out  1  chip select, active low.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: CS_N=1, SCLK=0. If ENABLE=1 and TX_EMPTY=0, drive TX_POP=1 for one cycle and go to LOAD. TX_POP is never asserted when TX_EMPTY=1.
- LOAD: shift register sr <= TX_DATA; bit counter := 0; divider := 0. CS_N goes low. Next state is SHIFT.
- SHIFT:
  - MOSI = sr[DATA_WIDTH-1] at all times during the state.
  - The divider counts 0..CLK_DIV-1. On the terminal count, SCLK toggles and the divider wraps to 0.
  - On the rising SCLK toggle: rx_bit <= MISO.
  - On the falling SCLK toggle: sr <= {sr[DATA_WIDTH-2:0], rx_bit}; bit counter increments.
  - The falling toggle that brings the bit counter to DATA_WIDTH moves the FSM to DONE.
- DONE: RX_DATA <= sr; RX_VALID=1; CS_N=1; SCLK=0. Next state is IDLE. Back-to-back frames re-arbitrate in IDLE.
- Deasserting ENABLE mid-frame does not abort the frame; it completes normally.
- Widths:
  - Divider: $clog2(CLK_DIV), minimum 1 bit.
  - Bit counter: $clog2(DATA_WIDTH+1).
  - All counters wrap only by explicit reset to 0.

## Timing
- Reset values: TX_POP=0, RX_DATA=0, RX_VALID=0, BUSY=0, SCLK=0, MOSI=0, CS_N=1, state IDLE.
- PRESET mid-frame: the next edge returns to IDLE with reset values. There is no RX_VALID pulse, and the popped word is discarded.
- Frame latency is 2*DATA_WIDTH*CLK_DIV + 2 cycles from TX_POP to RX_VALID:
  - TX_POP at cycle t, LOAD at t+1.
  - SHIFT occupies t+2 .. t+1+2*DATA_WIDTH*CLK_DIV.
  - RX_VALID at t+2+2*DATA_WIDTH*CLK_DIV.
- Minimum CS_N-high gap between frames: 2 cycles (DONE + IDLE).
- SCLK period: 2*CLK_DIV PCLK cycles, 50% duty cycle.
- The first rising SCLK edge occurs CLK_DIV cycles after SHIFT entry.
- MOSI changes only at LOAD and on falling SCLK toggles.
- All outputs are registered; no combinational path from input to output.

## Configuration
- SPI_LOOPBACK_EN:
  - Defined: MISO is ignored and the internal rx_bit is sampled from MOSI, so RX_DATA equals the transmitted word.
  - Undefined: rx_bit is sampled from the MISO port.
  - Port list is identical in both builds.

## Structure
- Package spi_pkg holds:
  - typedef enum logic [1:0] spi_state_t {IDLE, LOAD, SHIFT, DONE};
  - default width constants shared with the FIFO and register block.
- Sub-module spi_clk_div:
  - Parameter: CLK_DIV.
  - Inputs: PCLK, PRESET, run.
  - Outputs: SCLK plus rise_tick and fall_tick, one-cycle pulses.
  - Used by spi_shifter in SHIFT; held cleared outside SHIFT.

## Test plan
- Reset, then TX_EMPTY=1 and ENABLE=1 for 50 cycles -> TX_POP never asserted, CS_N=1, BUSY=0.
- SPI_LOOPBACK_EN defined, DATA_WIDTH=8, CLK_DIV=2, TX_DATA=8'hA5 -> MOSI sequence 1,0,1,0,0,1,0,1; RX_DATA=8'hA5; RX_VALID exactly 34 cycles after TX_POP.
- Loopback off, MISO driven with 8'h3C bit-serially on falling edges -> RX_DATA=8'h3C, one RX_VALID pulse.
- Two words queued (8'h01, 8'h80), ENABLE held high -> two TX_POP pulses 36 cycles apart; CS_N high for exactly 2 cycles between frames.
- PRESET asserted at SHIFT cycle 10 -> next cycle CS_N=1, SCLK=0, BUSY=0; no RX_VALID pulse; RX_DATA=0.
- ENABLE dropped during SHIFT with FIFO non-empty -> current frame completes with RX_VALID; no further TX_POP while ENABLE=0.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared declarations for the SPI peripheral: the shift-engine state encoding,
// default frame/divider sizes used by the TX FIFO, register block and shifter,
// and a helper that sizes the SCLK divider counter.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } spi_state_t;

   // Defaults shared across the peripheral.
   localparam int SPI_DATA_WIDTH = 8;
   localparam int SPI_CLK_DIV    = 2;

   // Divider counter width: $clog2(CLK_DIV), never narrower than one bit.
   function automatic int div_width(input int clk_div);
      return (clk_div > 1) ? $clog2(clk_div) : 1;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// SCLK generator for the SPI shift engine. While run is high the divider counts
// 0..CLK_DIV-1 and SCLK toggles on each terminal count, giving a 50% duty SCLK
// of period 2*CLK_DIV PCLK cycles that starts low. While run is low the divider
// and SCLK are held cleared.
//
// Ports:
//   PCLK      in   peripheral clock
//   PRESET    in   synchronous active-high reset
//   run       in   enable counting (high only while the shifter is in SHIFT)
//   SCLK      out  registered SPI clock
//   rise_tick out  one-cycle pulse: SCLK goes high at the next PCLK edge
//   fall_tick out  one-cycle pulse: SCLK goes low at the next PCLK edge
// -----------------------------------------------------------------------------
module spi_clk_div
   import spi_pkg::*;
#(
   parameter int CLK_DIV = SPI_CLK_DIV
) (
   input  logic PCLK,
   input  logic PRESET,
   input  logic run,
   output logic SCLK,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int               DIV_W    = div_width(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             sclk_q, sclk_d;
   logic             tick;

   always_comb begin
      tick   = run && (div_q == DIV_LAST);
      div_d  = div_q;
      sclk_d = sclk_q;
      if (!run) begin
         div_d  = '0;
         sclk_d = 1'b0;
      end else if (tick) begin
         div_d  = '0;
         sclk_d = ~sclk_q;
      end else begin
         div_d  = div_q + 1'b1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

   // Ticks announce the toggle that happens at the coming edge.
   assign rise_tick = tick && !sclk_q;
   assign fall_tick = tick &&  sclk_q;
   assign SCLK      = sclk_q;

endmodule

// File: rtl/spi_shifter.sv
// -----------------------------------------------------------------------------
// spi_shifter
// SPI mode-0 master shift engine fed by the TX FIFO. Pops one word when data is
// available and ENABLE is high, shifts it out MSB-first on MOSI while capturing
// MISO, and presents the received word on RX_DATA with a one-cycle RX_VALID.
//
// Build option: SPI_LOOPBACK_EN -- when defined, the receive bit is taken from
// the outgoing MOSI bit instead of the MISO port (MISO is ignored), so RX_DATA
// equals the transmitted word. The port list is the same in both builds.
//
// Ports:
//   PCLK      in   peripheral clock
//   PRESET    in   synchronous active-high reset
//   ENABLE    in   permits a new frame to start (looked at only in IDLE)
//   TX_EMPTY  in   TX FIFO empty flag
//   TX_DATA   in   FIFO read data, valid the cycle after TX_POP
//   TX_POP    out  one-cycle FIFO read strobe
//   RX_DATA   out  last received word, held until the next frame completes
//   RX_VALID  out  one-cycle pulse when RX_DATA updates
//   BUSY      out  high whenever the FSM is not in IDLE
//   SCLK      out  SPI clock, idles low
//   MOSI      out  serial data out
//   MISO      in   serial data in
//   CS_N      out  active-low chip select
//
// Handshake: TX_POP is a single-cycle strobe issued only after TX_EMPTY was
// seen low; the word is taken from TX_DATA in the following (LOAD) cycle.
// RX_VALID is a single-cycle strobe with no back-pressure; RX_DATA stays
// stable until the next RX_VALID.
// -----------------------------------------------------------------------------
module spi_shifter
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_DATA_WIDTH,
   parameter int CLK_DIV    = SPI_CLK_DIV
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  ENABLE,
   input  logic                  TX_EMPTY,
   input  logic [DATA_WIDTH-1:0] TX_DATA,
   output logic                  TX_POP,
   output logic [DATA_WIDTH-1:0] RX_DATA,
   output logic                  RX_VALID,
   output logic                  BUSY,
   output logic                  SCLK,
   output logic                  MOSI,
   input  logic                  MISO,
   output logic                  CS_N
);

   localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   spi_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] sr_q, sr_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  rx_bit_q, rx_bit_d;
   logic                  tx_pop_q, tx_pop_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  busy_q, busy_d;
   logic                  cs_n_q, cs_n_d;

   logic                  div_run;
   logic                  rise_tick;
   logic                  fall_tick;
   logic                  rx_src;

   assign div_run = (state_q == SHIFT);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .run       (div_run),
      .SCLK      (SCLK),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

`ifdef SPI_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = MISO;
   assign rx_src      = sr_q[DATA_WIDTH-1];
`else
   assign rx_src      = MISO;
`endif

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      rx_data_d  = rx_data_q;
      bit_cnt_d  = bit_cnt_q;
      rx_bit_d   = rx_bit_q;
      tx_pop_d   = 1'b0;
      rx_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            // The pop strobe is registered, so the strobe cycle itself is
            // spent in IDLE; LOAD follows once the FIFO has seen it.
            if (tx_pop_q) begin
               state_d = LOAD;
            end else if (ENABLE && !TX_EMPTY) begin
               tx_pop_d = 1'b1;
            end
         end
         LOAD: begin
            sr_d      = TX_DATA;
            bit_cnt_d = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            if (rise_tick) begin
               rx_bit_d = rx_src;
            end
            if (fall_tick) begin
               sr_d      = {sr_q[DATA_WIDTH-2:0], rx_bit_q};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CNT_LAST) begin
                  // Publish on the same edge DONE is entered so RX_DATA and
                  // RX_VALID line up in the DONE cycle.
                  rx_data_d  = sr_d;
                  rx_valid_d = 1'b1;
                  state_d    = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      // Chip select drops together with the pop strobe, so between frames it
      // is high only for the DONE cycle and one arbitration cycle in IDLE.
      cs_n_d = !(tx_pop_d || (state_d == LOAD) || (state_d == SHIFT));
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         rx_data_q  <= '0;
         bit_cnt_q  <= '0;
         rx_bit_q   <= 1'b0;
         tx_pop_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         cs_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         rx_data_q  <= rx_data_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_bit_q   <= rx_bit_d;
         tx_pop_q   <= tx_pop_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
         cs_n_q     <= cs_n_d;
      end
   end

   // MOSI is the shift register MSB, which only changes at the end of LOAD
   // and on falling SCLK toggles.
   assign MOSI     = sr_q[DATA_WIDTH-1];
   assign TX_POP   = tx_pop_q;
   assign RX_DATA  = rx_data_q;
   assign RX_VALID = rx_valid_q;
   assign BUSY     = busy_q;
   assign CS_N     = cs_n_q;

endmodule

// File: tb/tb_spi_shifter.sv
// -----------------------------------------------------------------------------
// tb_spi_shifter
// Directed bench for spi_shifter (DATA_WIDTH=8, CLK_DIV=2). A FIFO model feeds
// TX_DATA, a slave model drives MISO (or MISO is tied to MOSI for loopback
// frames), and a scoreboard holds the expected RX word and MOSI pattern per
// frame, compared when RX_VALID pulses.
// -----------------------------------------------------------------------------
module tb_spi_shifter;

   localparam int W   = 8;
   localparam int DIV = 2;
   localparam int LAT = 2 * W * DIV + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT connections ----------------
   logic         enable   = 1'b0;
   logic         tx_empty = 1'b1;
   logic [W-1:0] tx_data  = '0;
   logic         tx_pop;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         busy;
   logic         sclk;
   logic         mosi;
   logic         miso;
   logic         cs_n;

   logic         lb_mode  = 1'b0;
   logic [W-1:0] slave_sr = '0;

   assign miso = lb_mode ? mosi : slave_sr[W-1];

   spi_shifter #(
      .DATA_WIDTH (W),
      .CLK_DIV    (DIV)
   ) dut (
      .PCLK     (clk),
      .PRESET   (rst),
      .ENABLE   (enable),
      .TX_EMPTY (tx_empty),
      .TX_DATA  (tx_data),
      .TX_POP   (tx_pop),
      .RX_DATA  (rx_data),
      .RX_VALID (rx_valid),
      .BUSY     (busy),
      .SCLK     (sclk),
      .MOSI     (mosi),
      .MISO     (miso),
      .CS_N     (cs_n)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] fifo[$];
   logic [W-1:0] miso_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_tx_q[$];

   int n_cmp = 0;
   int n_err = 0;

   int cyc = 0;
   int last_pop_cyc = 0;
   int pop_gap = 0;
   int pop_cnt = 0;
   int rx_cnt = 0;
   int rise_cnt = 0;
   int cs_hi_len = 0;
   int cs_gap = 0;
   logic sclk_prev = 1'b0;
   logic cs_prev = 1'b1;
   logic [W-1:0] mosi_cap = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] tx, input logic [W-1:0] mi, input logic lb);
      fifo.push_back(tx);
      miso_q.push_back(mi);
      exp_tx_q.push_back(tx);
      exp_q.push_back(lb ? tx : mi);
   endtask

   task automatic wait_rx(input int target);
      int k = 0;
      while (rx_cnt < target && k < 2000) begin
         tick(1);
         k++;
      end
      chk("rx_count_wait", rx_cnt, target);
   endtask

   task automatic wait_pop(input int target);
      int k = 0;
      while (pop_cnt < target && k < 2000) begin
         tick(1);
         k++;
      end
      chk("pop_count_wait", pop_cnt, target);
   endtask

   // ---------------- monitor: FIFO model, slave model, scoreboard ----------------
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (tx_pop) begin
            chk("pop_while_empty", tx_empty, 1'b0);
            if (pop_cnt > 0) pop_gap = cyc - last_pop_cyc;
            last_pop_cyc = cyc;
            pop_cnt++;
            rise_cnt = 0;
            mosi_cap = '0;
            if (fifo.size() > 0) tx_data = fifo.pop_front();
            if (miso_q.size() > 0) slave_sr = miso_q.pop_front();
         end
         if (sclk && !sclk_prev) begin
            mosi_cap = {mosi_cap[W-2:0], mosi};
            rise_cnt++;
         end
         if (!sclk && sclk_prev) begin
            slave_sr = {slave_sr[W-2:0], 1'b0};
         end
         if (rx_valid) begin
            rx_cnt++;
            if (exp_q.size() > 0 && exp_tx_q.size() > 0) begin
               chk("rx_data", rx_data, exp_q.pop_front());
               chk("mosi_sequence", mosi_cap, exp_tx_q.pop_front());
               chk("sclk_rises", rise_cnt, W);
               chk("pop_to_valid_latency", cyc - last_pop_cyc, LAT);
            end else begin
               chk("unexpected_rx_valid", rx_valid, 1'b0);
            end
         end
         if (cs_n) begin
            cs_hi_len++;
         end else begin
            if (cs_prev) cs_gap = cs_hi_len;
            cs_hi_len = 0;
         end
      end
      sclk_prev = sclk;
      cs_prev   = cs_n;
      tx_empty  = (fifo.size() == 0);
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic bad_cs;
      logic bad_busy;
      logic [W-1:0] rtx;
      logic [W-1:0] rmi;
      logic rlb;

      // Reset values
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("reset_tx_pop", tx_pop, 1'b0);
      chk("reset_rx_data", rx_data, '0);
      chk("reset_rx_valid", rx_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_sclk", sclk, 1'b0);
      chk("reset_mosi", mosi, 1'b0);
      chk("reset_cs_n", cs_n, 1'b1);

      // Empty FIFO with ENABLE high: nothing starts
      enable   = 1'b1;
      bad_cs   = 1'b0;
      bad_busy = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (!cs_n) bad_cs = 1'b1;
         if (busy) bad_busy = 1'b1;
      end
      chk("empty_no_pop", pop_cnt, 0);
      chk("empty_cs_low_seen", bad_cs, 1'b0);
      chk("empty_busy_seen", bad_busy, 1'b0);

      // Loopback frame 0xA5
      lb_mode = 1'b1;
      push(8'hA5, 8'h00, 1'b1);
      wait_rx(1);
      tick(2);
      chk("loopback_rx_hold", rx_data, 8'hA5);

      // MISO-driven frame 0x3C while transmitting 0xC3
      lb_mode = 1'b0;
      push(8'hC3, 8'h3C, 1'b0);
      wait_rx(2);
      tick(40);
      chk("single_rx_valid", rx_cnt, 2);
      chk("miso_rx_hold", rx_data, 8'h3C);

      // Two queued words back to back
      enable = 1'b0;
      push(8'h01, 8'h96, 1'b0);
      push(8'h80, 8'h69, 1'b0);
      tick(2);
      enable = 1'b1;
      wait_rx(4);
      chk("b2b_pop_gap", pop_gap, 36);
      chk("b2b_cs_high_gap", cs_gap, 2);
      tick(5);

      // Reset in the middle of SHIFT
      lb_mode = 1'b1;
      push(8'h5A, 8'h00, 1'b1);
      wait_pop(5);
      enable = 1'b0;
      tick(11);
      void'(exp_q.pop_back());
      void'(exp_tx_q.pop_back());
      rst = 1'b1;
      tick(1);
      chk("midreset_cs_n", cs_n, 1'b1);
      chk("midreset_sclk", sclk, 1'b0);
      chk("midreset_busy", busy, 1'b0);
      chk("midreset_rx_valid", rx_valid, 1'b0);
      chk("midreset_rx_data", rx_data, '0);
      chk("midreset_tx_pop", tx_pop, 1'b0);
      rst = 1'b0;
      tick(60);
      chk("midreset_no_rx", rx_cnt, 4);
      chk("midreset_no_pop", pop_cnt, 5);

      // ENABLE dropped mid-frame with FIFO still non-empty
      lb_mode = 1'b1;
      push(8'h55, 8'h00, 1'b1);
      push(8'hAA, 8'h00, 1'b1);
      tick(2);
      enable = 1'b1;
      wait_pop(6);
      tick(5);
      enable = 1'b0;
      wait_rx(5);
      tick(80);
      chk("disable_pop_count", pop_cnt, 6);
      chk("disable_rx_count", rx_cnt, 5);
      chk("disable_fifo_left", fifo.size(), 1);
      enable = 1'b1;
      wait_rx(6);
      enable = 1'b0;
      tick(5);

      // Random single frames, random loopback choice
      for (int i = 0; i < 4; i++) begin
         rtx = W'($urandom_range(0, 255));
         rmi = W'($urandom_range(0, 255));
         rlb = 1'($urandom_range(0, 1));
         lb_mode = rlb;
         push(rtx, rmi, rlb);
         enable = 1'b1;
         wait_rx(7 + i);
         enable = 1'b0;
         tick(3);
      end

      tick(10);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
